// File: rtl/row_vector_mac_if.sv
// Chunk/result handshake bundle between a row-by-vector feeder and row_vector_mac.
interface row_vector_mac_if #(
    parameter int unsigned NO_OF_UNITS   = 8,
    parameter int unsigned ELEMENT_WIDTH = 32,
    parameter int unsigned ACC_WIDTH     = 72
);
    localparam int unsigned CHUNK_WIDTH = NO_OF_UNITS * ELEMENT_WIDTH;

    logic                   start;
    logic [31:0]            no_of_multiples;
    logic [CHUNK_WIDTH-1:0] row_chunk;
    logic [CHUNK_WIDTH-1:0] vec_chunk;
    logic                   chunk_valid;
    logic                   chunk_ready;
    logic                   busy;
    logic [ACC_WIDTH-1:0]   result;
    logic                   result_valid;

    modport master (
        output start, no_of_multiples, row_chunk, vec_chunk, chunk_valid,
        input  chunk_ready, busy, result, result_valid
    );

    modport slave (
        input  start, no_of_multiples, row_chunk, vec_chunk, chunk_valid,
        output chunk_ready, busy, result, result_valid
    );
endinterface

// File: rtl/row_vector_mac.sv
// Streaming row-by-vector dot product: lane-wise multiply, registered adder tree,
// and per-row accumulation of no_of_multiples chunks.
module row_vector_mac #(
    parameter int unsigned NO_OF_UNITS   = 8,
    parameter int unsigned ELEMENT_WIDTH = 32,
    parameter int unsigned ACC_WIDTH     = 72
) (
    input  logic              clk,
    input  logic              rst_n,
    row_vector_mac_if.slave   bus
);
    localparam int unsigned PROD_WIDTH = 2 * ELEMENT_WIDTH;
    localparam int unsigned EXT_WIDTH  = ACC_WIDTH - PROD_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             count_q, count_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [PROD_WIDTH-1:0]   prod_q [NO_OF_UNITS];
    logic [PROD_WIDTH-1:0]   prod_d [NO_OF_UNITS];
    logic                    p1_valid_q, p1_valid_d;
    logic                    p1_last_q, p1_last_d;
    logic [ACC_WIDTH-1:0]    sum_q, sum_d;
    logic                    p2_valid_q, p2_valid_d;
    logic                    p2_last_q, p2_last_d;
    logic [ACC_WIDTH-1:0]    result_q, result_d;
    logic                    result_valid_q, result_valid_d;
    logic                    chunk_ready_q, chunk_ready_d;
    logic                    busy_q, busy_d;
    logic                    accept_c;
    logic                    last_c;

    assign accept_c = chunk_ready_q && bus.chunk_valid;
    assign last_c   = (cnt_q + 32'd1) == count_q;

    // Lane products (lane 0 sits in the MSBs) and the sign-extended tree sum.
    always_comb begin
        for (int i = 0; i < int'(NO_OF_UNITS); i++) begin
            prod_d[i] = PROD_WIDTH'($signed(bus.row_chunk[(NO_OF_UNITS-1-i)*ELEMENT_WIDTH +: ELEMENT_WIDTH]))
                      * PROD_WIDTH'($signed(bus.vec_chunk[(NO_OF_UNITS-1-i)*ELEMENT_WIDTH +: ELEMENT_WIDTH]));
        end
        sum_d = '0;
        for (int i = 0; i < int'(NO_OF_UNITS); i++) begin
            sum_d = sum_d + {{EXT_WIDTH{prod_q[i][PROD_WIDTH-1]}}, prod_q[i]};
        end
    end

    // Next-state, pipeline control and accumulation.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        p1_valid_d     = 1'b0;
        p1_last_d      = 1'b0;
        p2_valid_d     = p1_valid_q;
        p2_last_d      = p1_last_q;

        if (p2_valid_q) begin
            acc_d = acc_q + sum_q;
            if (p2_last_q) begin
                result_d       = acc_q + sum_q;
                result_valid_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.no_of_multiples == 32'd0) begin
                        result_d       = '0;
                        result_valid_d = 1'b1;
                    end else begin
                        count_d = bus.no_of_multiples;
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept_c) begin
                    cnt_d      = cnt_q + 32'd1;
                    p1_valid_d = 1'b1;
                    p1_last_d  = last_c;
                    if (last_c) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (p2_valid_q && p2_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        chunk_ready_d = (state_d == RUN);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            count_q        <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            p1_valid_q     <= 1'b0;
            p1_last_q      <= 1'b0;
            sum_q          <= '0;
            p2_valid_q     <= 1'b0;
            p2_last_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            chunk_ready_q  <= 1'b0;
            busy_q         <= 1'b0;
            for (int i = 0; i < int'(NO_OF_UNITS); i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            p1_valid_q     <= p1_valid_d;
            p1_last_q      <= p1_last_d;
            sum_q          <= sum_d;
            p2_valid_q     <= p2_valid_d;
            p2_last_q      <= p2_last_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            chunk_ready_q  <= chunk_ready_d;
            busy_q         <= busy_d;
            for (int i = 0; i < int'(NO_OF_UNITS); i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign bus.chunk_ready  = chunk_ready_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_row_vector_mac.sv
// Directed self-checking bench for row_vector_mac with hand-computed dot products.
module tb_row_vector_mac;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    row_vector_mac_if #(.NO_OF_UNITS(8), .ELEMENT_WIDTH(32), .ACC_WIDTH(72)) bus ();

    row_vector_mac #(.NO_OF_UNITS(8), .ELEMENT_WIDTH(32), .ACC_WIDTH(72)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] fill(input logic [31:0] v);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    // Lane i (lane 0 in the MSBs) holds i+1.
    function automatic logic [255:0] ramp();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[(7-i)*32 +: 32] = 32'(i + 1);
        return r;
    endfunction

    task automatic send(input logic [255:0] row, input logic [255:0] vec);
        bus.row_chunk   = row;
        bus.vec_chunk   = vec;
        bus.chunk_valid = 1'b1;
        tick();
        bus.chunk_valid = 1'b0;
    endtask

    // Watches a bounded window after the last accepting edge.
    task automatic drain(input string tag, input logic [71:0] exp);
        int          pulses;
        int          lat;
        logic [71:0] res;
        pulses = 0;
        lat    = 0;
        res    = '0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.result_valid === 1'b1) begin
                pulses++;
                if (lat == 0) lat = i;
                res = bus.result;
            end
        end
        chk({tag, "_pulses"},  72'(pulses), 72'd1);
        chk({tag, "_latency"}, 72'(lat),    72'd2);
        chk({tag, "_result"},  res,         exp);
        chk({tag, "_busy"},    72'(bus.busy), 72'd0);
    endtask

    initial begin
        n_assert            = 0;
        n_fail              = 0;
        rst_n               = 1'b0;
        bus.start           = 1'b0;
        bus.no_of_multiples = 32'd0;
        bus.row_chunk       = '0;
        bus.vec_chunk       = '0;
        bus.chunk_valid     = 1'b0;
        #3;
        chk("rst_result",       bus.result,             72'd0);
        chk("rst_result_valid", 72'(bus.result_valid),  72'd0);
        chk("rst_chunk_ready",  72'(bus.chunk_valid & 1'b0 | bus.chunk_ready), 72'd0);
        chk("rst_busy",         72'(bus.busy),          72'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // Basic row; a chunk presented together with start must be ignored.
        bus.start           = 1'b1;
        bus.no_of_multiples = 32'd1;
        bus.row_chunk       = fill(32'd100);
        bus.vec_chunk       = fill(32'd100);
        bus.chunk_valid     = 1'b1;
        tick();
        bus.start       = 1'b0;
        bus.chunk_valid = 1'b0;
        chk("basic_ready_run", 72'(bus.chunk_ready), 72'd1);
        chk("basic_busy_run",  72'(bus.busy),        72'd1);
        send(fill(32'd1), ramp());
        chk("basic_ready_drop", 72'(bus.chunk_ready), 72'd0);
        drain("basic", 72'd36);

        // Gapped stream of three chunks, with a stray start during RUN.
        bus.start           = 1'b1;
        bus.no_of_multiples = 32'd3;
        tick();
        bus.start     = 1'b0;
        bus.row_chunk = fill(32'd2);
        bus.vec_chunk = fill(32'd3);
        for (int j = 0; j < 5; j++) begin
            bus.chunk_valid     = (j % 2 == 0);
            bus.start           = (j == 1);
            bus.no_of_multiples = (j == 1) ? 32'd1 : 32'd3;
            tick();
            bus.start = 1'b0;
            if (j == 2) chk("gap_ready_mid", 72'(bus.chunk_ready), 72'd1);
        end
        bus.chunk_valid = 1'b0;
        chk("gap_ready_drop", 72'(bus.chunk_ready), 72'd0);
        drain("gap", 72'd144);

        // Signed extremes.
        bus.start           = 1'b1;
        bus.no_of_multiples = 32'd1;
        tick();
        bus.start = 1'b0;
        send(fill(32'hFFFF_FFFF), fill(32'h7FFF_FFFF));
        drain("signed", -72'sd17179869176);

        // Zero-length row.
        bus.start           = 1'b1;
        bus.no_of_multiples = 32'd0;
        tick();
        bus.start = 1'b0;
        chk("zero_valid",  72'(bus.result_valid), 72'd1);
        chk("zero_result", bus.result,            72'd0);
        chk("zero_busy",   72'(bus.busy),         72'd0);
        tick();
        chk("zero_valid_drop", 72'(bus.result_valid), 72'd0);
        chk("zero_busy_after", 72'(bus.busy),         72'd0);

        // Back-to-back rows, second start in the result_valid cycle.
        bus.start           = 1'b1;
        bus.no_of_multiples = 32'd2;
        tick();
        bus.start = 1'b0;
        send(fill(32'd1), fill(32'd1));
        send(fill(32'd1), fill(32'd2));
        tick();
        chk("b2b_valid_early", 72'(bus.result_valid), 72'd0);
        tick();
        chk("b2b_valid_first", 72'(bus.result_valid), 72'd1);
        chk("b2b_result_first", bus.result,           72'd24);
        bus.start           = 1'b1;
        bus.no_of_multiples = 32'd1;
        tick();
        bus.start = 1'b0;
        chk("b2b_ready_second", 72'(bus.chunk_ready), 72'd1);
        send(fill(32'd3), fill(32'hFFFF_FFFE));
        drain("b2b_second", -72'sd48);

        // Asynchronous reset in the middle of a row.
        bus.start           = 1'b1;
        bus.no_of_multiples = 32'd4;
        tick();
        bus.start = 1'b0;
        send(fill(32'd7), fill(32'd7));
        send(fill(32'd7), fill(32'd7));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_result", bus.result,             72'd0);
        chk("mid_rst_valid",  72'(bus.result_valid),  72'd0);
        chk("mid_rst_ready",  72'(bus.chunk_ready),   72'd0);
        chk("mid_rst_busy",   72'(bus.busy),          72'd0);
        #2;
        rst_n = 1'b1;
        tick();
        bus.start           = 1'b1;
        bus.no_of_multiples = 32'd1;
        tick();
        bus.start = 1'b0;
        send(fill(32'd5), fill(32'd1));
        drain("post_rst", 72'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
